// File: rtl/handshake_fork_eager_pkg.sv
// Shared handshake helpers: parameter legality checks used at elaboration time.
package handshake_fork_eager_pkg;

  function automatic bit fork_params_ok(input int size, input int data_width);
    return (size >= 1) && (data_width >= 1);
  endfunction

endpackage

// File: rtl/handshake_fork_emit_reg.sv
// One fork leg: remembers whether this output already took the current token.
module handshake_fork_emit_reg (
  input  logic clk,
  input  logic rst,
  input  logic ins_valid,
  input  logic retire,
  input  logic outs_ready,
  output logic outs_valid,
  output logic done
);

  logic emitted;

  assign outs_valid = ins_valid & ~emitted;
  assign done       = emitted | outs_ready;

  // Retirement wins over setting, so a leg whose last copy transfers in the
  // retiring cycle starts the next token clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      emitted <= 1'b0;
    end else if (retire) begin
      emitted <= 1'b0;
    end else begin
      emitted <= emitted | (outs_valid & outs_ready);
    end
  end

endmodule

// File: rtl/handshake_fork_eager.sv
// Eager fork: copies one valid/ready stream to SIZE consumers; the input is
// acknowledged once every consumer has taken its copy.
module handshake_fork_eager
  import handshake_fork_eager_pkg::*;
#(
  parameter int SIZE       = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      ins,
  input  logic                       ins_valid,
  output logic                       ins_ready,
  output logic [SIZE*DATA_WIDTH-1:0] outs,
  output logic [SIZE-1:0]            outs_valid,
  input  logic [SIZE-1:0]            outs_ready
);

  if (!fork_params_ok(SIZE, DATA_WIDTH)) begin : g_bad_params
    $error("handshake_fork_eager: SIZE and DATA_WIDTH must both be >= 1");
  end

  logic [SIZE-1:0] done;
  logic            retire;

  // ins_ready depends only on emitted state and outs_ready, never on ins_valid.
  assign ins_ready = &done;
  assign retire    = ins_valid & ins_ready;
  assign outs      = {SIZE{ins}};

  for (genvar i = 0; i < SIZE; i++) begin : g_leg
    handshake_fork_emit_reg u_emit (
      .clk        (clk),
      .rst        (rst),
      .ins_valid  (ins_valid),
      .retire     (retire),
      .outs_ready (outs_ready[i]),
      .outs_valid (outs_valid[i]),
      .done       (done[i])
    );
  end

endmodule
